// File: rtl/mdll_pkg.sv
// MDLL loop controller shared types: FSM state and phase-detector decision
// encodings, plus the midscale code helper.
package mdll_pkg;

  // Encoding is visible on state_out: 0 IDLE, 1 SEARCH, 2 TRACK, 3 LOCKED.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } mdll_state_t;

  // One decision per settle window, derived from the synchronised PD pulses.
  typedef enum logic [1:0] {
    DEC_NONE = 2'd0,
    DEC_UP   = 2'd1,
    DEC_DN   = 2'd2
  } mdll_dec_t;

  // Midscale of a code_w-bit delay-line code: MSB set, all other bits clear.
  function automatic int unsigned mdll_midscale(input int unsigned code_w);
    return 32'd1 << (code_w - 32'd1);
  endfunction

endpackage

// File: rtl/mdll_sync2.sv
// Two-flop synchroniser for one phase-detector pulse line.
// Asynchronous active-low reset clears both stages to 0.
module mdll_sync2 (
  input  logic clk_in,
  input  logic ff_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the asynchronous input through two stages before any use.
  always_ff @(posedge clk_in or negedge ff_rst) begin
    if (!ff_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/mdll_loop_ctrl.sv
// MDLL digital loop controller.
// Consumes lead/lag pulses from the phase detector and drives the delay-line
// code: binary-search acquisition (MSB to LSB), then +/-1 tracking with
// lock detection (alternating decisions) and unlock detection (same-direction
// runs). One decision is taken every SETTLE_CYC+1 cycles of clk_in.
//
// Build option: define MDLL_LOCK_FREEZE_EN to hold code_out constant while
// LOCKED; decisions still feed the unlock run counter.
module mdll_loop_ctrl
  import mdll_pkg::*;
#(
  parameter int CODE_W     = 6,
  parameter int SETTLE_CYC = 4,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic              clk_in,
  input  logic              ff_rst,
  input  logic              enable,
  input  logic              lead,
  input  logic              lag,
  output logic [CODE_W-1:0] code_out,
  output logic              locked,
  output logic [1:0]        state_out,
  output logic              sat_hi,
  output logic              sat_lo
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 2);
  localparam int ALT_W = $clog2(LOCK_CNT + 2);
  localparam int RUN_W = $clog2(UNLOCK_CNT + 2);
  localparam int PTR_W = (CODE_W > 2) ? $clog2(CODE_W) : 1;

  localparam logic [CODE_W-1:0] MID_CODE  = CODE_W'(mdll_midscale(CODE_W));
  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYC);
  localparam logic [ALT_W-1:0]  LOCK_LIM  = ALT_W'(LOCK_CNT);
  localparam logic [RUN_W-1:0]  RUN_LIM   = RUN_W'(UNLOCK_CNT);
  localparam logic [PTR_W-1:0]  PTR_MSB   = PTR_W'(CODE_W - 1);

  // Synchronised PD pulses
  logic w_lead_s;
  logic w_lag_s;

  // FSM and datapath registers
  mdll_state_t       r_state;
  logic [CODE_W-1:0] r_code;
  logic [PTR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_settle;
  logic [ALT_W-1:0]  r_alt;
  logic [RUN_W-1:0]  r_run;
  mdll_dec_t         r_prev;
  logic              r_locked;
  logic              r_sat_hi;
  logic              r_sat_lo;

  // Combinational helpers
  mdll_dec_t         w_dec;
  logic              w_settle_done;
  logic [CODE_W-1:0] w_srch_code;
  logic [CODE_W-1:0] w_trk_code;
  logic              w_trk_hi;
  logic              w_trk_lo;
  logic [CODE_W-1:0] w_lk_code;
  logic              w_lk_hi;
  logic              w_lk_lo;
  logic [ALT_W-1:0]  w_alt_nxt;
  logic [RUN_W-1:0]  w_run_nxt;

  mdll_sync2 u_sync_lead (
    .clk_in (clk_in),
    .ff_rst (ff_rst),
    .i_d    (lead),
    .o_q    (w_lead_s)
  );

  mdll_sync2 u_sync_lag (
    .clk_in (clk_in),
    .ff_rst (ff_rst),
    .i_d    (lag),
    .o_q    (w_lag_s)
  );

  assign w_settle_done = (r_settle == SETTLE_LD);

  // Map synchronised pulses to a decision; both or neither high is NONE.
  always_comb begin
    w_dec = DEC_NONE;
    if (w_lead_s && !w_lag_s) begin
      w_dec = DEC_UP;
    end else if (w_lag_s && !w_lead_s) begin
      w_dec = DEC_DN;
    end
  end

  // Binary-search step: resolve the current bit, then trial-set the next one.
  always_comb begin
    w_srch_code = r_code;
    if (w_dec == DEC_DN) begin
      w_srch_code[r_ptr] = 1'b0;
    end
    if (r_ptr != '0) begin
      w_srch_code[r_ptr - 1'b1] = 1'b1;
    end
  end

  // Tracking step: +/-1 with saturation; a saturated request only flags.
  always_comb begin
    w_trk_code = r_code;
    w_trk_hi   = 1'b0;
    w_trk_lo   = 1'b0;
    case (w_dec)
      DEC_UP: begin
        if (r_code == '1) begin
          w_trk_hi = 1'b1;
        end else begin
          w_trk_code = r_code + 1'b1;
        end
      end
      DEC_DN: begin
        if (r_code == '0) begin
          w_trk_lo = 1'b1;
        end else begin
          w_trk_code = r_code - 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef MDLL_LOCK_FREEZE_EN
  assign w_lk_code = r_code;
  assign w_lk_hi   = 1'b0;
  assign w_lk_lo   = 1'b0;
`else
  assign w_lk_code = w_trk_code;
  assign w_lk_hi   = w_trk_hi;
  assign w_lk_lo   = w_trk_lo;
`endif

  // Lock/unlock counters. The first decision after IDLE has no predecessor
  // and leaves the alternation count untouched; a new direction starts a
  // same-direction run of length 1.
  always_comb begin
    w_alt_nxt = r_alt;
    w_run_nxt = r_run;
    if (w_dec != DEC_NONE) begin
      if (r_prev == w_dec) begin
        w_alt_nxt = '0;
        w_run_nxt = r_run + 1'b1;
      end else begin
        w_run_nxt = RUN_W'(1);
        if (r_prev != DEC_NONE) begin
          w_alt_nxt = r_alt + 1'b1;
        end
      end
    end
  end

  // Loop FSM: settle timing, code update, lock state and saturation pulses.
  always_ff @(posedge clk_in or negedge ff_rst) begin
    if (!ff_rst) begin
      r_state  <= IDLE;
      r_code   <= MID_CODE;
      r_ptr    <= '0;
      r_settle <= '0;
      r_alt    <= '0;
      r_run    <= '0;
      r_prev   <= DEC_NONE;
      r_locked <= 1'b0;
      r_sat_hi <= 1'b0;
      r_sat_lo <= 1'b0;
    end else begin
      r_sat_hi <= 1'b0;
      r_sat_lo <= 1'b0;
      if (!enable) begin
        r_state  <= IDLE;
        r_code   <= MID_CODE;
        r_ptr    <= '0;
        r_settle <= '0;
        r_alt    <= '0;
        r_run    <= '0;
        r_prev   <= DEC_NONE;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state  <= SEARCH;
            r_code   <= MID_CODE;
            r_ptr    <= PTR_MSB;
            r_settle <= '0;
          end

          SEARCH: begin
            if (w_settle_done) begin
              r_settle <= '0;
              r_code   <= w_srch_code;
              if (r_ptr != '0) begin
                r_ptr <= r_ptr - 1'b1;
              end else begin
                r_state <= TRACK;
              end
            end else begin
              r_settle <= r_settle + 1'b1;
            end
          end

          TRACK: begin
            if (w_settle_done) begin
              r_settle <= '0;
              if (w_dec != DEC_NONE) begin
                r_code   <= w_trk_code;
                r_sat_hi <= w_trk_hi;
                r_sat_lo <= w_trk_lo;
                r_prev   <= w_dec;
                if (w_alt_nxt == LOCK_LIM) begin
                  r_state  <= LOCKED;
                  r_locked <= 1'b1;
                  r_alt    <= '0;
                  r_run    <= '0;
                end else begin
                  r_alt <= w_alt_nxt;
                end
              end
            end else begin
              r_settle <= r_settle + 1'b1;
            end
          end

          LOCKED: begin
            if (w_settle_done) begin
              r_settle <= '0;
              if (w_dec != DEC_NONE) begin
                r_code   <= w_lk_code;
                r_sat_hi <= w_lk_hi;
                r_sat_lo <= w_lk_lo;
                r_prev   <= w_dec;
                if (w_run_nxt == RUN_LIM) begin
                  r_state  <= TRACK;
                  r_locked <= 1'b0;
                  r_alt    <= '0;
                  r_run    <= '0;
                end else begin
                  r_run <= w_run_nxt;
                end
              end
            end else begin
              r_settle <= r_settle + 1'b1;
            end
          end

          default: begin
            r_state <= IDLE;
            r_code  <= MID_CODE;
          end
        endcase
      end
    end
  end

  assign code_out  = r_code;
  assign locked    = r_locked;
  assign state_out = r_state;
  assign sat_hi    = r_sat_hi;
  assign sat_lo    = r_sat_lo;

endmodule

// File: tb/tb_mdll_loop_ctrl.sv
// Directed bench for mdll_loop_ctrl with a closed-loop phase-detector model:
// lead when code < target, lag when code > target, and at code == target an
// alternation that starts with lead on the first step spent there and then
// flips every step.
module tb_mdll_loop_ctrl;

  localparam int SETTLE = 4;

  logic       clk_in = 1'b0;
  logic       ff_rst;
  logic       enable;
  logic       lead;
  logic       lag;
  logic [5:0] code_out;
  logic       locked;
  logic [1:0] state_out;
  logic       sat_hi;
  logic       sat_lo;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  int tgt  = 0;
  bit anch = 1'b0;
  bit ph   = 1'b0;

  mdll_loop_ctrl #(
    .CODE_W     (6),
    .SETTLE_CYC (SETTLE),
    .LOCK_CNT   (8),
    .UNLOCK_CNT (4)
  ) dut (
    .clk_in    (clk_in),
    .ff_rst    (ff_rst),
    .enable    (enable),
    .lead      (lead),
    .lag       (lag),
    .code_out  (code_out),
    .locked    (locked),
    .state_out (state_out),
    .sat_hi    (sat_hi),
    .sat_lo    (sat_lo)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic set_tgt(input int t);
    tgt  = t;
    anch = 1'b0;
    ph   = 1'b0;
  endtask

  // Phase-detector model, evaluated once at the start of each step.
  task automatic pd_drive();
    int c;
    c = int'(code_out);
    if (anch) ph = ~ph;
    if (c == tgt && !anch) begin
      anch = 1'b1;
      ph   = 1'b1;
    end
    if (c < tgt)      begin lead = 1'b1; lag = 1'b0; end
    else if (c > tgt) begin lead = 1'b0; lag = 1'b1; end
    else              begin lead = ph;   lag = ~ph;  end
  endtask

  // One full decision step; returns on the negedge after the decision edge.
  task automatic step();
    pd_drive();
    repeat (SETTLE + 1) @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // Raise enable; the following posedge enters SEARCH.
  task automatic start();
    enable = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int exp_acq[6];
    exp_acq = '{16, 24, 20, 22, 23, 23};

    ff_rst = 1'b0; enable = 1'b0; lead = 1'b0; lag = 1'b0;

    // 1. Reset state
    repeat (2) @(negedge clk_in);
    chk("rst_code_in_reset", code_out, 32);
    ff_rst = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("rst_code", code_out, 32);
    chk("rst_locked", locked, 0);
    chk("rst_state", state_out, 0);
    chk("rst_sat_hi", sat_hi, 0);
    chk("rst_sat_lo", sat_lo, 0);

    // 2. Acquisition toward 23
    set_tgt(23);
    start();
    chk("acq_state_entry", state_out, 1);
    chk("acq_code_entry", code_out, 32);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("acq_code_s%0d", k), code_out, exp_acq[k]);
      chk($sformatf("acq_state_s%0d", k), state_out, (k < 5) ? 1 : 2);
    end

    // 3. Dither 23/22 until the 8th alternation locks
    for (int k = 6; k <= 14; k++) begin
      step();
      chk($sformatf("lock_code_s%0d", k), code_out, (k % 2 == 0) ? 22 : 23);
      chk($sformatf("lock_state_s%0d", k), state_out, (k == 14) ? 3 : 2);
      chk($sformatf("lock_flag_s%0d", k), locked, (k == 14) ? 1 : 0);
    end

    // 4. Target jumps to 30: four UPs unlock, climb, re-lock
    set_tgt(30);
    for (int k = 15; k <= 31; k++) begin
      int ec;
      int es;
      step();
      if (k <= 22)       ec = k + 8;
      else if (k % 2)    ec = 31;
      else               ec = 30;
      es = (k <= 17 || k == 31) ? 3 : 2;
      chk($sformatf("unl_code_s%0d", k), code_out, ec);
      chk($sformatf("unl_state_s%0d", k), state_out, es);
      chk($sformatf("unl_flag_s%0d", k), locked, (es == 3) ? 1 : 0);
    end

    // 5. Target beyond full scale: unlock, climb to 63, saturate
    set_tgt(70);
    for (int k = 32; k <= 63; k++) begin
      step();
      chk($sformatf("sat_code_s%0d", k), code_out, k);
      chk($sformatf("sat_hi_s%0d", k), sat_hi, 0);
    end
    chk("sat_state_track", state_out, 2);
    step();
    chk("sat_hi_pulse1", sat_hi, 1);
    chk("sat_code_hold1", code_out, 63);
    chk("sat_lo_idle", sat_lo, 0);
    pd_drive();
    @(posedge clk_in);
    @(negedge clk_in);
    chk("sat_hi_cleared", sat_hi, 0);
    repeat (SETTLE) @(posedge clk_in);
    @(negedge clk_in);
    chk("sat_hi_pulse2", sat_hi, 1);
    chk("sat_code_hold2", code_out, 63);

    // 6a. enable low from TRACK returns to IDLE/midscale next cycle
    enable = 1'b0;
    @(negedge clk_in);
    chk("dis_trk_state", state_out, 0);
    chk("dis_trk_code", code_out, 32);

    // 6b. enable low mid-SEARCH
    set_tgt(23);
    start();
    step();
    step();
    chk("abort_pre_code", code_out, 24);
    pd_drive();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("abort_pre_state", state_out, 1);
    enable = 1'b0;
    @(posedge clk_in);
    #1;
    chk("abort_state", state_out, 0);
    chk("abort_code", code_out, 32);
    chk("abort_locked", locked, 0);

    // 6c. asynchronous reset mid-TRACK
    @(negedge clk_in);
    set_tgt(23);
    start();
    for (int k = 0; k < 8; k++) step();
    chk("arst_pre_state", state_out, 2);
    chk("arst_pre_code", code_out, 23);
    @(posedge clk_in);
    #2;
    ff_rst = 1'b0;
    #1;
    chk("arst_code", code_out, 32);
    chk("arst_state", state_out, 0);
    chk("arst_locked", locked, 0);
    chk("arst_sat_hi", sat_hi, 0);
    enable = 1'b0;
    @(negedge clk_in);
    ff_rst = 1'b1;
    @(negedge clk_in);
    chk("arst_post_state", state_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
